// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns one-hot low, classifies each full
// scan frame, and debounces presses/releases into a 4-bit key code with a strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key,
  output logic       o_valid,
  output logic       o_pressed
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TGT   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  function automatic logic [2:0] count_low(input logic [3:0] rows);
    logic [3:0] low;
    low = ~rows;
    return {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else idx = 2'd3;
    return idx;
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [1:0]    col_idx_r;
  logic [DW-1:0] dwell_r;
  logic [3:0]    col_r;
  logic [1:0]    frame_cnt_r;
  logic [3:0]    frame_code_r;
  state_t        state_r, state_next_s;
  logic [3:0]    cand_r, cand_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [3:0]    key_r, key_next_s;
  logic          valid_r, valid_next_s;
  logic          pressed_r, pressed_next_s;

  logic          sample_s, frame_done_s;
  logic [1:0]    col_next_s;
  logic [2:0]    lows_s, frame_sum_s;
  logic [1:0]    acc_base_s, frame_cnt_next_s;
  logic [3:0]    frame_code_next_s;
  logic          res_key_s, res_none_s;

  assign sample_s     = (dwell_r == DWELL_MAX);
  assign frame_done_s = sample_s && (col_idx_r == 2'd3);
  assign col_next_s   = col_idx_r + 2'd1;
  assign lows_s       = count_low(row_sync_r);
  // Column 0 starts a fresh frame; the contact count saturates at 2 (MULTI).
  assign acc_base_s   = (col_idx_r == 2'd0) ? 2'd0 : frame_cnt_r;
  assign frame_sum_s  = {1'b0, acc_base_s} + lows_s;
  assign frame_cnt_next_s  = (frame_sum_s >= 3'd2) ? 2'd2 : frame_sum_s[1:0];
  assign frame_code_next_s = (lows_s == 3'd1) ? {low_index(row_sync_r), col_idx_r} :
                             ((col_idx_r == 2'd0) ? 4'd0 : frame_code_r);
  assign res_key_s  = (frame_cnt_next_s == 2'd1);
  assign res_none_s = (frame_cnt_next_s == 2'd0);

  // Row synchronizer, column scan and per-frame contact accumulation.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      row_meta_r   <= 4'b1111;
      row_sync_r   <= 4'b1111;
      col_idx_r    <= 2'd0;
      dwell_r      <= '0;
      col_r        <= 4'b1110;
      frame_cnt_r  <= 2'd0;
      frame_code_r <= 4'd0;
    end else begin
      row_meta_r <= i_row;
      row_sync_r <= row_meta_r;
      if (sample_s) begin
        dwell_r      <= '0;
        col_idx_r    <= col_next_s;
        col_r        <= ~(4'b0001 << col_next_s);
        frame_cnt_r  <= frame_cnt_next_s;
        frame_code_r <= frame_code_next_s;
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= IDLE;
      cand_r    <= 4'd0;
      cnt_r     <= '0;
      key_r     <= 4'd0;
      valid_r   <= 1'b0;
      pressed_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cand_r    <= cand_next_s;
      cnt_r     <= cnt_next_s;
      key_r     <= key_next_s;
      valid_r   <= valid_next_s;
      pressed_r <= pressed_next_s;
    end
  end

  // Debounce FSM next state; only advances on frame completion.
  always_comb begin
    state_next_s   = state_r;
    cand_next_s    = cand_r;
    cnt_next_s     = cnt_r;
    key_next_s     = key_r;
    valid_next_s   = 1'b0;
    pressed_next_s = pressed_r;
    if (frame_done_s) begin
      case (state_r)
        IDLE: begin
          if (res_key_s) begin
            state_next_s = PRESS_DB;
            cand_next_s  = frame_code_next_s;
            cnt_next_s   = CNT_ONE;
          end else begin
            state_next_s = IDLE;
          end
        end
        PRESS_DB: begin
          if (res_key_s && (frame_code_next_s == cand_r)) begin
            if (cnt_r + CNT_ONE == CNT_TGT) begin
              state_next_s   = HELD;
              key_next_s     = cand_r;
              valid_next_s   = 1'b1;
              pressed_next_s = 1'b1;
            end else begin
              cnt_next_s = cnt_r + CNT_ONE;
            end
          end else if (res_key_s) begin
            cand_next_s = frame_code_next_s;
            cnt_next_s  = CNT_ONE;
          end else begin
            state_next_s = IDLE;
          end
        end
        HELD: begin
          if (res_none_s) begin
            state_next_s = REL_DB;
            cnt_next_s   = CNT_ONE;
          end else begin
            state_next_s = HELD;
          end
        end
        REL_DB: begin
          if (res_none_s) begin
            if (cnt_r + CNT_ONE == CNT_TGT) begin
              state_next_s   = IDLE;
              pressed_next_s = 1'b0;
            end else begin
              cnt_next_s = cnt_r + CNT_ONE;
            end
          end else begin
            state_next_s = HELD;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  assign o_col     = col_r;
  assign o_key     = key_r;
  assign o_valid   = valid_r;
  assign o_pressed = pressed_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: a keypad contact model drives the rows,
// a frame-level reference predicts strobes into a queue checked by a monitor.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [3:0] i_row;
  logic [3:0] o_col, o_key;
  logic       o_valid, o_pressed;

  logic [15:0] mask;  // contact closed at index row*4+col

  int errors = 0;
  int checks = 0;

  typedef struct { logic [3:0] key; int cyc; } exp_t;
  exp_t q[$];

  // Reference-model state
  int         cyc;
  logic [15:0] m1, m2;
  int         f_n;
  logic [3:0] f_code;
  bit         m_pressed;
  logic [3:0] m_key;
  logic [3:0] cand;
  int         run, nrun;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_row(i_row),
    .o_col(o_col), .o_key(o_key), .o_valid(o_valid), .o_pressed(o_pressed)
  );

  always #5 i_clk = ~i_clk;

  // A row reads low when a closed contact sits on a column being driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      i_row[r] = !(|(mask[r*4 +: 4] & ~o_col));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a column is sampled every SD cycles using contacts
  // as they stood two cycles earlier; every 4th sample closes a frame.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc = 0; m1 = '0; m2 = '0; f_n = 0; f_code = 4'd0;
      m_pressed = 1'b0; m_key = 4'd0; cand = 4'd0; run = 0; nrun = 0;
      q.delete();
    end else begin
      cyc++;
      if (cyc % SD == 0) begin
        int c;
        c = ((cyc / SD) + 3) % 4;
        if (c == 0) f_n = 0;
        for (int r = 0; r < 4; r++)
          if (m2[r*4 + c]) begin
            f_n++;
            f_code = 4'(r * 4 + c);
          end
        if (c == 3) begin
          if (!m_pressed) begin
            if (f_n == 1) begin
              if (run > 0 && f_code == cand) run++;
              else begin cand = f_code; run = 1; end
              if (run == DB) begin
                m_pressed = 1'b1; m_key = cand; run = 0; nrun = 0;
                q.push_back('{key: cand, cyc: cyc});
              end
            end else begin
              run = 0;
            end
          end else begin
            if (f_n == 0) begin
              nrun++;
              if (nrun == DB) begin m_pressed = 1'b0; nrun = 0; run = 0; end
            end else begin
              nrun = 0;
            end
          end
        end
      end
      m2 = m1;
      m1 = mask;
    end
  end

  // Monitor: pops the expected strobe whenever the DUT pulses o_valid.
  always @(negedge i_clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("valid_missed", 0, 1);
      void'(q.pop_front());
    end
    if (o_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("valid_key", int'(o_key), int'(e.key));
      end
    end
    chk("o_col", int'(o_col), int'(~(4'b0001 << ((cyc / SD) % 4)) & 4'hF));
    chk("o_pressed", int'(o_pressed), int'(m_pressed));
    chk("o_key", int'(o_key), int'(m_key));
  end

  task automatic hold(input logic [15:0] m, input int n);
    mask = m;
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    i_reset_n = 1'b0;
    mask = '0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;

    // Idle, clean press of key 9, release
    hold(16'h0000, 200);
    hold(16'h0200, 100);
    hold(16'h0000, 100);

    // Bounce, then stable; short release with re-press gives no new strobe
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 16'h0200 : 16'h0000, 10);
    hold(16'h0200, 100);
    hold(16'h0000, 20);
    hold(16'h0200, 100);
    hold(16'h0000, 100);

    // Two keys together, then drop key 15
    hold(16'h8001, 160);
    hold(16'h0001, 100);
    hold(16'h0000, 100);

    // Asynchronous reset during press debounce
    hold(16'h0200, 40);
    @(posedge i_clk);
    #3 i_reset_n = 1'b0;
    #1;
    chk("rst_o_col", int'(o_col), 14);
    chk("rst_o_key", int'(o_key), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_pressed", int'(o_pressed), 0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    hold(16'h0200, 100);
    hold(16'h0000, 100);

    // Random mix of no key, single keys and key pairs
    for (int i = 0; i < 60; i++) begin
      logic [15:0] m;
      int sel;
      sel = $urandom_range(0, 3);
      m = '0;
      if (sel >= 1) m[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) m[$urandom_range(0, 15)] = 1'b1;
      hold(m, $urandom_range(8, 120));
    end
    hold(16'h0000, 100);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces it and encodes the pressed key into a 4-bit code with a one-cycle valid strobe.
- It is the input end of the display path: the display side decodes a 4-bit value into segment and digit drive; this block encodes physical key contacts into the 4-bit operand values that feed the adder/display path.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before advancing; must be >= 4.
- DEBOUNCE_CNT, 8, consecutive identical scan frames required to accept a press or a release; must be >= 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_row  input  4  keypad rows, active-low, externally pulled up, asynchronous to i_clk.
- o_col  output  4  keypad column drive, active-low one-hot.
- o_key  output  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- o_valid  output  1  one-cycle pulse when o_key is updated with a new press.
- o_pressed  output  1  high while the accepted key is held (debounced level).

Behaviour:
- Reset (async assert, sync release) sets:
  - o_col=4'b1110, o_key=0, o_valid=0, o_pressed=0.
  - column index 0, dwell counter 0, FSM=IDLE, debounce counter 0, row synchronizer=4'b1111.
- Input sync: i_row passes through a 2-flop synchronizer before use.
- Column scan:
  - Column index c in 0..3 drives o_col[c]=0 and all other bits 1.
  - Dwell counter runs 0..SCAN_DIV-1.
  - When dwell==SCAN_DIV-1, the synchronized rows are sampled for column c, c advances (3 wraps to 0) and dwell resets.
- Frame:
  - One frame is 4 consecutive column samples, i.e. 4*SCAN_DIV cycles.
  - A frame completes on the column-3 sample.
  - Frame result is KEY(code) if exactly one contact was low across all 16 positions, NONE if zero, MULTI if two or more.
- FSM, evaluated only at frame completion:
  - IDLE: KEY(k) -> PRESS_DB, cand=k, cnt=1. NONE/MULTI -> stay.
  - PRESS_DB:
    - KEY(cand) -> cnt+1. When cnt+1==DEBOUNCE_CNT -> HELD, with o_key=cand, o_valid=1 for exactly one cycle and o_pressed=1, all registered in the cycle after frame completion.
    - KEY(j), j!=cand -> cand=j, cnt=1, stay.
    - NONE/MULTI -> IDLE.
  - HELD:
    - NONE -> REL_DB, cnt=1.
    - KEY(any) or MULTI -> stay. A second key while held is ignored, with no new strobe.
  - REL_DB:
    - NONE -> cnt+1. When cnt+1==DEBOUNCE_CNT -> IDLE with o_pressed=0.
    - KEY/MULTI -> HELD, no new strobe.
- o_key holds its value after release until the next accepted press.
- o_valid is never high for two consecutive cycles.
- Latency: a press that is stable before a frame starts yields o_valid 1 cycle after the DEBOUNCE_CNT-th matching frame completes. The worst case from contact closure is (DEBOUNCE_CNT+1)*4*SCAN_DIV+3 cycles.
- Reset mid-operation: all state returns to reset values immediately. No strobe is issued for a press that was in progress.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame=16 cycles):
1. Reset then idle: rows all 1 for 200 cycles.
   - o_col cycles 1110, 1101, 1011, 0111, each held 4 cycles.
   - o_valid never asserts; o_pressed=0, o_key=0.
2. Clean press of row 2/col 1 (row[2]=0 whenever o_col[1]=0), held 100 cycles.
   - Exactly one o_valid pulse, with o_key=4'b1001 and o_pressed=1 from that cycle.
   - The pulse occurs 1 cycle after the third full matching frame.
3. Bounce: same key toggled every 10 cycles for 60 cycles, then stable.
   - No o_valid during bouncing.
   - A single o_valid with o_key=9 after 3 stable frames.
4. Release:
   - After scenario 2, all rows go high. o_pressed falls 1 cycle after the 3rd NONE frame; o_key stays 9.
   - Re-pressing the key after only 1 NONE frame gives no new o_valid.
5. Multi-key: row0/col0 and row3/col3 pressed together from IDLE.
   - No o_valid and o_pressed stays 0 for 10 frames.
   - Releasing row3/col3 yields o_valid with o_key=0.
6. Reset mid-debounce: i_reset_n pulsed low during PRESS_DB (after 2 matching frames), asynchronous to the clock edge.
   - Outputs return to reset values within the same cycle.
   - Exactly one strobe follows, 3 frames after reset release.
